// File: rtl/encoding_slot_dm_gen_pkg.sv
// Shared types and helpers for the multichannel delta-modulation encoding slot.
package encoding_pkg;

    localparam int SPIKE_W = 2;

    typedef struct packed {
        logic pos;
        logic neg;
    } spike_pair_t;

    // Bits needed to index 'value' entries, never less than one.
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    // Slot i occupies {pos,neg} at bits [i*2+1 : i*2], so slot 0 is the group's first channel.
    function automatic int slot_lsb(input int slot);
        return slot * SPIKE_W;
    endfunction

endpackage

// File: rtl/encoding_slot_dm_gen_packer.sv
// Serial-to-parallel packer: gathers P consecutive {pos,neg} pairs into one 2P-bit word.
module dm_packer
    import encoding_pkg::*;
#(
    parameter int P = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  spike_pair_t          in,
    output logic [SPIKE_W*P-1:0] word,
    output logic                 valid,
    output logic                 active_group
);

    localparam int KW = clogb2(P);
    localparam int WW = SPIKE_W * P;

    logic [KW-1:0] k_q, k_d;
    logic [WW-1:0] slots_q, slots_d;
    logic [WW-1:0] word_q, word_d;
    logic          valid_q, valid_d;
    logic          active_q, active_d;

    // The completed word is assembled from the stored partial slots plus the pair arriving now.
    always_comb begin
        k_d      = k_q;
        slots_d  = slots_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        active_d = 1'b0;
        if (clr) begin
            k_d     = '0;
            slots_d = '0;
        end else if (in_valid) begin
            slots_d[slot_lsb(int'(k_q)) +: SPIKE_W] = in;
            if (k_q == KW'(P - 1)) begin
                word_d   = slots_d;
                valid_d  = 1'b1;
                active_d = |slots_d;
                k_d      = '0;
                slots_d  = '0;
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q      <= '0;
            slots_q  <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            k_q      <= k_d;
            slots_q  <= slots_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            active_q <= active_d;
        end
    end

    assign word         = word_q;
    assign valid        = valid_q;
    assign active_group = active_q;

endmodule

// File: rtl/encoding_slot_dm_gen.sv
// Time-multiplexed multichannel delta modulator with per-channel reference store,
// programmable threshold latched per frame, and packed spike output.
module encoding_slot_dm_gen
    import encoding_pkg::*;
#(
    parameter int CHANNELS = 128,
    parameter int DW       = 8,
    parameter int P        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 soft_clr,
    input  logic [DW-1:0]        data_in,
    input  logic [DW-1:0]        delta,
    output logic [SPIKE_W*P-1:0] spike_bin,
    output logic                 valid_bin,
    output logic                 active_group_out_bin,
    output logic                 frame_done
);

    localparam int                    CW      = clogb2(CHANNELS);
    localparam logic [CW-1:0]         LAST_CH = CW'(CHANNELS - 1);
    localparam logic signed [DW+1:0]  REF_MAX = $signed({3'b000, {(DW-1){1'b1}}});
    localparam logic signed [DW+1:0]  REF_MIN = $signed({3'b111, {(DW-1){1'b0}}});

    logic [CW-1:0]       ch_q;
    logic [DW-1:0]       delta_q;
    logic                s1_valid_q;
    logic [DW-1:0]       s1_data_q;
    logic [DW-1:0]       s1_ref_q;
    logic                s1_init_q;
    logic [CW-1:0]       s1_ch_q;
    logic [DW-1:0]       ref_q [CHANNELS];
    logic [CHANNELS-1:0] init_q;
    logic                frame_q;

    logic signed [DW:0]   diff, dqs;
    logic signed [DW+1:0] ref_up, ref_dn;
    logic [DW-1:0]        ref_new;
    logic                 ref_wr, init_set;
    spike_pair_t          s2_pair;

    // Stage 1: capture the sample with its channel's reference; the threshold only moves at channel 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q       <= '0;
            delta_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_ref_q   <= '0;
            s1_init_q  <= 1'b0;
            s1_ch_q    <= '0;
        end else begin
            s1_valid_q <= en && !soft_clr;
            if (soft_clr) begin
                ch_q <= '0;
            end else if (en) begin
                ch_q      <= (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
                s1_data_q <= data_in;
                s1_ref_q  <= ref_q[ch_q];
                s1_init_q <= init_q[ch_q];
                s1_ch_q   <= ch_q;
                if (ch_q == '0) begin
                    delta_q <= delta;
                end
            end
        end
    end

    // Stage 2: compare in DW+1 bits so the difference never wraps; reference moves saturate.
    always_comb begin
        diff     = $signed({s1_data_q[DW-1], s1_data_q}) - $signed({s1_ref_q[DW-1], s1_ref_q});
        dqs      = $signed({1'b0, delta_q});
        ref_up   = $signed({{2{s1_ref_q[DW-1]}}, s1_ref_q}) + $signed({2'b00, delta_q});
        ref_dn   = $signed({{2{s1_ref_q[DW-1]}}, s1_ref_q}) - $signed({2'b00, delta_q});
        s2_pair  = '0;
        ref_new  = s1_ref_q;
        ref_wr   = 1'b0;
        init_set = 1'b0;
        if (s1_valid_q) begin
            if (!s1_init_q) begin
                ref_new  = s1_data_q;
                ref_wr   = 1'b1;
                init_set = 1'b1;
            end else if (delta_q == '0) begin
                ref_new = s1_data_q;
                ref_wr  = 1'b1;
            end else if (diff >= dqs) begin
                s2_pair.pos = 1'b1;
                ref_new     = (ref_up > REF_MAX) ? REF_MAX[DW-1:0] : ref_up[DW-1:0];
                ref_wr      = 1'b1;
            end else if (diff <= -dqs) begin
                s2_pair.neg = 1'b1;
                ref_new     = (ref_dn < REF_MIN) ? REF_MIN[DW-1:0] : ref_dn[DW-1:0];
                ref_wr      = 1'b1;
            end
        end
    end

    // A soft clear discards the in-flight writeback; references are deliberately left stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ref_q[c] <= '0;
            end
            init_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= s1_valid_q && !soft_clr && (s1_ch_q == LAST_CH);
            if (soft_clr) begin
                init_q <= '0;
            end else begin
                if (ref_wr) begin
                    ref_q[s1_ch_q] <= ref_new;
                end
                if (init_set) begin
                    init_q[s1_ch_q] <= 1'b1;
                end
            end
        end
    end

    dm_packer #(.P(P)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr          (soft_clr),
        .in_valid     (s1_valid_q),
        .in           (s2_pair),
        .word         (spike_bin),
        .valid        (valid_bin),
        .active_group (active_group_out_bin)
    );

    assign frame_done = frame_q;

endmodule

// File: tb/tb_encoding_slot_dm_gen.sv
// Self-checking bench for encoding_slot_dm_gen: directed frames plus a randomized run against a behavioural model.
module tb_encoding_slot_dm_gen;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int P  = 2;
    localparam int WW = 2 * P;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          soft_clr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] delta = '0;
    logic [WW-1:0] spike_bin;
    logic          valid_bin;
    logic          active_group_out_bin;
    logic          frame_done;

    encoding_slot_dm_gen #(.CHANNELS(CH), .DW(DW), .P(P)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .en                   (en),
        .soft_clr             (soft_clr),
        .data_in              (data_in),
        .delta                (delta),
        .spike_bin            (spike_bin),
        .valid_bin            (valid_bin),
        .active_group_out_bin (active_group_out_bin),
        .frame_done           (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int word;
        bit frame;
    } exp_t;

    exp_t expq[$];
    int   cap[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   edgeN      = 0;

    int mref[CH];
    bit minit[CH];
    int mdelta = 0;
    int mch    = 0;
    int mslot  = 0;
    int mword  = 0;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: one accepted sample at a time, plain integer arithmetic.
    function automatic void modelAccept(input int s, input int dl, input int cyc);
        int   d;
        int   pair;
        exp_t e;
        if (mch == 0) mdelta = dl;
        d    = s - mref[mch];
        pair = 0;
        if (!minit[mch]) begin
            mref[mch]  = s;
            minit[mch] = 1'b1;
        end else if (mdelta == 0) begin
            mref[mch] = s;
        end else if (d >= mdelta) begin
            pair      = 2;
            mref[mch] = (mref[mch] + mdelta > 127) ? 127 : mref[mch] + mdelta;
        end else if (d <= -mdelta) begin
            pair      = 1;
            mref[mch] = (mref[mch] - mdelta < -128) ? -128 : mref[mch] - mdelta;
        end
        mword = mword | (pair << (2 * mslot));
        mslot++;
        if (mslot == P) begin
            e.cyc   = cyc + 1;
            e.word  = mword;
            e.frame = (mch == CH - 1);
            expq.push_back(e);
            mslot = 0;
            mword = 0;
        end
        mch = (mch + 1) % CH;
    endfunction

    function automatic void modelClear(input int cyc);
        mch   = 0;
        mslot = 0;
        mword = 0;
        for (int c = 0; c < CH; c++) minit[c] = 1'b0;
        while (expq.size() > 0 && expq[expq.size()-1].cyc >= cyc) void'(expq.pop_back());
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (expq.size() > 0 && expq[0].cyc == edgeN) begin
            e = expq.pop_front();
            checkOne("valid_bin", {31'd0, valid_bin}, 32'd1);
            checkOne("spike_bin", {{(32-WW){1'b0}}, spike_bin}, e.word);
            checkOne("active_group", {31'd0, active_group_out_bin}, {31'd0, (e.word != 0)});
            checkOne("frame_done", {31'd0, frame_done}, {31'd0, e.frame});
        end else begin
            checkOne("valid_bin idle", {31'd0, valid_bin}, 32'd0);
            checkOne("frame_done idle", {31'd0, frame_done}, 32'd0);
        end
        if (valid_bin === 1'b1) cap.push_back(int'(spike_bin));
    endtask

    task automatic applyStimulus(input logic e, input int s, input int dl, input logic c);
        @(negedge clk);
        en       = e;
        data_in  = DW'(s);
        delta    = DW'(dl);
        soft_clr = c;
        @(posedge clk);
        edgeN++;
        if (c) modelClear(edgeN);
        else if (e) modelAccept(s, dl, edgeN);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 0, 0, 1'b0);
    endtask

    task automatic sendFrame(input int s0, input int s1, input int s2, input int s3,
                             input int dA, input int dB);
        applyStimulus(1'b1, s0, dA, 1'b0);
        applyStimulus(1'b1, s1, dA, 1'b0);
        applyStimulus(1'b1, s2, dB, 1'b0);
        applyStimulus(1'b1, s3, dB, 1'b0);
    endtask

    initial begin
        bit prevAcc;
        int curDelta;
        bit e;
        bit c;
        int s;

        for (int i = 0; i < CH; i++) begin
            mref[i]  = 0;
            minit[i] = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        checkOne("reset spike_bin", {{(32-WW){1'b0}}, spike_bin}, 32'd0);
        checkOne("reset valid_bin", {31'd0, valid_bin}, 32'd0);
        checkOne("reset active_group", {31'd0, active_group_out_bin}, 32'd0);
        checkOne("reset frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Init frame: references captured, no spikes.
        cap.delete();
        sendFrame(5, -3, 100, -128, 10, 10);
        idle(3);
        checkOne("init count", cap.size(), 32'd2);
        checkOne("init w0", cap[0], 32'd0);
        checkOne("init w1", cap[1], 32'd0);

        // Threshold crossings in both directions.
        cap.delete();
        sendFrame(15, -14, 110, -117, 10, 10);
        idle(3);
        checkOne("thr count", cap.size(), 32'd2);
        checkOne("thr w0", cap[0], 32'h6);
        checkOne("thr w1", cap[1], 32'hA);

        // Reference near positive full scale.
        cap.delete();
        sendFrame(120, 0, 0, 0, 0, 0);
        sendFrame(127, 0, 0, 0, 20, 20);
        sendFrame(127, 0, 0, 0, 5, 5);
        sendFrame(127, 0, 0, 0, 2, 2);
        sendFrame(127, 0, 0, 0, 2, 2);
        idle(3);
        checkOne("sat count", cap.size(), 32'd10);
        checkOne("sat d0", cap[0], 32'd0);
        checkOne("sat d20", cap[2], 32'd0);
        checkOne("sat d5", cap[4], 32'h2);
        checkOne("sat d2 a", cap[6], 32'h2);
        checkOne("sat d2 b", cap[8], 32'd0);

        // Threshold changed mid-frame only takes effect at the next channel 0.
        cap.delete();
        sendFrame(127, 0, 20, -20, 10, 50);
        sendFrame(127, 0, 40, -40, 50, 50);
        idle(3);
        checkOne("latch w1 old delta", cap[1], 32'h6);
        checkOne("latch w1 new delta", cap[3], 32'd0);

        // Soft clear after a partial group, coinciding with a dropped sample.
        cap.delete();
        applyStimulus(1'b1, 50, 10, 1'b0);
        applyStimulus(1'b1, 50, 10, 1'b0);
        applyStimulus(1'b1, 50, 10, 1'b0);
        idle(1);
        applyStimulus(1'b1, 99, 10, 1'b1);
        idle(2);
        checkOne("clr partial count", cap.size(), 32'd1);
        cap.delete();
        sendFrame(50, 60, 70, 80, 10, 10);
        sendFrame(65, 45, 70, 80, 10, 10);
        idle(3);
        checkOne("clr reinit w0", cap[0], 32'd0);
        checkOne("clr reinit w1", cap[1], 32'd0);
        checkOne("clr next w0", cap[2], 32'h6);

        // Randomized run, soft clears only after a cycle with nothing accepted.
        prevAcc  = 1'b0;
        curDelta = 10;
        for (int i = 0; i < 400; i++) begin
            c = !prevAcc && ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0)
                curDelta = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
            s = int'($urandom_range(0, 255)) - 128;
            applyStimulus(e, s, curDelta, c);
            prevAcc = e && !c;
        end
        idle(3);
        checkOne("drain pending", expq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/encoding_slot_dm_gen.md
Name: encoding_slot_dm_gen

Overview:
Parametrised successor to the fixed 4-bit delta-modulation encoding slot. It is a time-multiplexed, multichannel delta modulator with a run-time programmable threshold, per-channel first-sample initialisation and a saturating reference. It packs the pos/neg spikes of P consecutive channels into one 2P-bit word. It sits between the sample front-end and the SNN input FIFO/spike bus.

Parameters:
CHANNELS, 128, number of time-multiplexed channels; must be a multiple of P and at least 2.
DW, 8, signed sample width, also the delta width.
P, 2, channels packed per output word; valid values 1..16; output word is 2P bits.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
en  in  1  one sample of the current channel is presented on data_in.
soft_clr  in  1  synchronous clear: channel counter, packer and all init flags; references are left stale.
data_in  in  DW  signed sample; channels arrive strictly in order 0..CHANNELS-1, then wrap.
delta  in  DW  unsigned threshold; latched when an en for channel 0 is accepted.
spike_bin  out  2P  packed spikes {pos[P-1],neg[P-1],...,pos[0],neg[0]}; index 0 is the first channel of the group.
valid_bin  out  1  one-cycle strobe; spike_bin is valid.
active_group_out_bin  out  1  OR of all spike_bin bits; qualified by valid_bin.
frame_done  out  1  one-cycle strobe, coincident with the valid_bin of the group containing channel CHANNELS-1.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0.
  - channel counter 0, packer count 0, delta_q 0.
  - all init flags cleared.
- Channel counter: increments on each accepted en; wraps CHANNELS-1 -> 0.
- Reference store: CHANNELS x DW registers/RAM ref[c] plus a CHANNELS-bit init vector.
- Stage 1 (cycle of en): read ref[ch] and init[ch]; register data_in, ch and delta_q.
  - delta_q updates from delta only when ch==0, so it is constant across a frame.
- Stage 2 (next cycle): compute diff = data_in - ref as a DW+1 signed value, then:
  - init[ch]==0: ref <= data_in; init[ch] <= 1; pos=neg=0.
  - delta_q==0: ref <= data_in; pos=neg=0 (encoding disabled).
  - diff >= delta_q: pos=1; ref <= min(ref+delta_q, 2^(DW-1)-1).
  - diff <= -delta_q: neg=1; ref <= max(ref-delta_q, -2^(DW-1)).
  - otherwise: pos=neg=0; ref unchanged.
  - pos and neg are never both 1.
- Packer (sub-module): on each stage-2 result, writes {pos,neg} to slot k (k = packer count), then increments k.
  - On k==P-1, the next cycle drives spike_bin and pulses valid_bin for 1 cycle, then resets k to 0.
  - spike_bin holds its value until the next valid_bin.
- Latency: en of the last channel of a group -> valid_bin exactly 2 cycles later.
- Throughput: one en per cycle sustained; back-to-back en across group and frame boundaries produces no bubbles or drops.
- Same-channel hazard: cannot occur because CHANNELS >= 2. Stage-2 writeback completes before that channel is read again.
- soft_clr with en in the same cycle: soft_clr wins; the sample is dropped.
  - Stage-1/2 contents in flight are discarded.
  - No valid_bin is produced from a partially filled group.
- rst mid-frame: same as soft_clr, plus references and delta_q cleared.
- en=0 gaps: the pipeline holds; the packer keeps its partial group indefinitely.

Decomposition:
- Package encoding_pkg holds:
  - the clogb2 function.
  - the typedef spike_pair_t {logic pos; logic neg;}.
  - the localparam SPIKE_W=2 and the spike_bin bit-ordering helper.
- Sub-module dm_packer #(P) generalises the serial-to-parallel stage.
  - Inputs: clk, rst, clr, in_valid, spike_pair_t in.
  - Outputs: word, valid, active_group.
- Delta logic and the reference store stay in the top module.

Test Plan:
1. Init: CHANNELS=4, P=2, delta=10; frame 1 samples {5,-3,100,-128}.
   -> Two valid_bin strobes, both spike_bin=0, frame_done with the second strobe.
2. Threshold: frame 2 samples {15,-14,110,-117} vs refs {5,-3,100,-128}.
   -> Word0 = {pos1=0,neg1=1,pos0=1,neg0=0} = 4'b0110.
   -> Word1: ch2 diff=10 gives pos, ch3 diff=11 gives pos = 4'b1010.
   -> active_group=1 on both words.
3. Saturation: DW=8, ref=120, delta=20, sample=127.
   -> No spike, since diff=7 < 20.
   -> With delta=5: pos=1 and ref becomes 125, then 127 on the next pos (clamped, never wraps negative).
4. Delta latch: change delta from 10 to 50 while ch=2 of the frame is being presented.
   -> Ch2 and ch3 still use 10; the new value takes effect from the next channel 0.
5. soft_clr after 3 of 4 channels.
   -> No valid_bin for the partial group; counter restarts at 0.
   -> The next frame behaves as the init frame (all spikes 0).
6. Stress: P=4, CHANNELS=16, en held high for 64 cycles, random data vs a scoreboard model.
   -> Exactly 16 valid_bin strobes, 4 frame_done strobes, bit-exact spike_bin, latency 2 cycles.
